// File: rtl/rename_map_if.sv
// Bundles the decode, rename-output, wakeup-broadcast and commit signals of
// rename_map; slave is the rename stage, master is whoever drives it.
interface rename_map_if #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(PHYS_REGS + 1);

  logic                 STALL;
  logic                 FLUSH;
  // dec_valid/dec_ready: an instruction transfers on a cycle where both are
  // high; dec_ready never depends on dec_valid, and a held instruction may wait.
  logic                 dec_valid;
  logic [31:0]          dec_instr_num;
  logic [AW-1:0]        dec_src_a;
  logic [AW-1:0]        dec_src_b;
  logic [AW-1:0]        dec_dst;
  logic                 dec_wr;
  logic                 dec_ready;
  logic                 ren_valid;
  logic [31:0]          ren_instr_num;
  logic [PW-1:0]        ren_map_a;
  logic [PW-1:0]        ren_map_b;
  logic [PW-1:0]        ren_map_wr;
  logic [PHYS_REGS-1:0] busy;
  logic [CW-1:0]        free_count;
  logic                 exe_broadcast;
  logic [PW-1:0]        exe_broadcast_map;
  logic                 mem_broadcast;
  logic [PW-1:0]        mem_broadcast_map;
  logic                 commit_valid;
  logic [AW-1:0]        commit_dst;
  logic [PW-1:0]        commit_map;

  modport master (
    output STALL, FLUSH, dec_valid, dec_instr_num, dec_src_a, dec_src_b,
           dec_dst, dec_wr, exe_broadcast, exe_broadcast_map, mem_broadcast,
           mem_broadcast_map, commit_valid, commit_dst, commit_map,
    input  dec_ready, ren_valid, ren_instr_num, ren_map_a, ren_map_b,
           ren_map_wr, busy, free_count
  );

  modport slave (
    input  STALL, FLUSH, dec_valid, dec_instr_num, dec_src_a, dec_src_b,
           dec_dst, dec_wr, exe_broadcast, exe_broadcast_map, mem_broadcast,
           mem_broadcast_map, commit_valid, commit_dst, commit_map,
    output dec_ready, ren_valid, ren_instr_num, ren_map_a, ren_map_b,
           ren_map_wr, busy, free_count
  );
endinterface

// File: rtl/rename_map.sv
// Register-rename stage: speculative RAT, committed RRAT, free list and busy
// vector. Define RENAME_CHECK_EN to add simulation-only consistency checks.
module rename_map #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  rename_map_if.slave bus
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(PHYS_REGS + 1);
  localparam logic [PHYS_REGS-1:0] RESET_FREE =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PW-1:0]        rat_q  [ARCH_REGS];
  logic [PW-1:0]        rat_d  [ARCH_REGS];
  logic [PW-1:0]        rrat_q [ARCH_REGS];
  logic [PW-1:0]        rrat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]        free_cnt_q, free_cnt_d;
  logic                 ren_valid_q, ren_valid_d;
  logic [31:0]          ren_num_q, ren_num_d;
  logic [PW-1:0]        map_a_q, map_a_d;
  logic [PW-1:0]        map_b_q, map_b_d;
  logic [PW-1:0]        map_wr_q, map_wr_d;

  logic                 need;
  logic                 dec_ready;
  logic                 accept;
  logic                 alloc_found;
  logic [PW-1:0]        alloc_idx;
  logic [PW-1:0]        old_map;
  logic [PHYS_REGS-1:0] rrat_ref;

  assign need      = bus.dec_wr && (bus.dec_dst != '0);
  assign dec_ready = !bus.STALL && !bus.FLUSH && (!need || (free_cnt_q != '0));
  assign accept    = bus.dec_valid && dec_ready;

  // Lowest free register from the pre-commit free list; reg 0 is never a candidate.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int p = PHYS_REGS - 1; p >= 1; p--) begin
      if (free_q[p]) begin
        alloc_found = 1'b1;
        alloc_idx   = PW'(p);
      end
    end
  end

  always_comb begin
    rat_d       = rat_q;
    rrat_d      = rrat_q;
    free_d      = free_q;
    busy_d      = busy_q;
    ren_valid_d = 1'b0;
    ren_num_d   = '0;
    map_a_d     = '0;
    map_b_d     = '0;
    map_wr_d    = '0;
    old_map     = '0;
    rrat_ref    = '0;

    if (bus.commit_valid && (bus.commit_dst != '0)) begin
      old_map                = rrat_q[bus.commit_dst];
      rrat_d[bus.commit_dst] = bus.commit_map;
      if (old_map != '0) free_d[old_map] = 1'b1;
    end

    for (int i = 0; i < ARCH_REGS; i++) rrat_ref[rrat_d[i]] = 1'b1;

    if (bus.FLUSH) begin
      // Recovery rebuilds the free list from the post-commit committed map.
      rat_d     = rrat_d;
      free_d    = ~rrat_ref;
      free_d[0] = 1'b0;
      busy_d    = '0;
    end else begin
      if (bus.exe_broadcast && (bus.exe_broadcast_map != '0))
        busy_d[bus.exe_broadcast_map] = 1'b0;
      if (bus.mem_broadcast && (bus.mem_broadcast_map != '0))
        busy_d[bus.mem_broadcast_map] = 1'b0;
      if (accept) begin
        ren_valid_d = 1'b1;
        ren_num_d   = bus.dec_instr_num;
        map_a_d     = rat_q[bus.dec_src_a];
        map_b_d     = rat_q[bus.dec_src_b];
        if (need && alloc_found) begin
          map_wr_d            = alloc_idx;
          rat_d[bus.dec_dst]  = alloc_idx;
          free_d[alloc_idx]   = 1'b0;
          busy_d[alloc_idx]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_cnt_d = '0;
    for (int p = 0; p < PHYS_REGS; p++) free_cnt_d = free_cnt_d + CW'(free_d[p]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        rrat_q[i] <= PW'(i);
      end
      free_q      <= RESET_FREE;
      busy_q      <= '0;
      free_cnt_q  <= CW'(PHYS_REGS - ARCH_REGS);
      ren_valid_q <= 1'b0;
      ren_num_q   <= '0;
      map_a_q     <= '0;
      map_b_q     <= '0;
      map_wr_q    <= '0;
    end else begin
      rat_q       <= rat_d;
      rrat_q      <= rrat_d;
      free_q      <= free_d;
      busy_q      <= busy_d;
      free_cnt_q  <= free_cnt_d;
      ren_valid_q <= ren_valid_d;
      ren_num_q   <= ren_num_d;
      map_a_q     <= map_a_d;
      map_b_q     <= map_b_d;
      map_wr_q    <= map_wr_d;
    end
  end

  assign bus.dec_ready     = dec_ready;
  assign bus.ren_valid     = ren_valid_q;
  assign bus.ren_instr_num = ren_num_q;
  assign bus.ren_map_a     = map_a_q;
  assign bus.ren_map_b     = map_b_q;
  assign bus.ren_map_wr    = map_wr_q;
  assign bus.busy          = busy_q;
  assign bus.free_count    = free_cnt_q;

`ifdef RENAME_CHECK_EN
  always @(posedge CLK) begin
    if (!RESET) begin
      if (bus.commit_valid && (bus.commit_dst != '0) && free_q[rrat_q[bus.commit_dst]]) begin
        $display("RENAME ERROR at %0t: commit frees an already-free register", $time);
        $stop;
      end
      if (bus.commit_valid && (bus.commit_dst != '0) &&
          ((bus.commit_map == '0) || free_q[bus.commit_map])) begin
        $display("RENAME ERROR at %0t: commit_map %0d not allocated", $time, bus.commit_map);
        $stop;
      end
      if ((bus.exe_broadcast && (bus.exe_broadcast_map == '0)) ||
          (bus.mem_broadcast && (bus.mem_broadcast_map == '0))) begin
        $display("RENAME ERROR at %0t: broadcast of map 0", $time);
        $stop;
      end
      if ((bus.exe_broadcast && (bus.exe_broadcast_map != '0) && !busy_q[bus.exe_broadcast_map]) ||
          (bus.mem_broadcast && (bus.mem_broadcast_map != '0) && !busy_q[bus.mem_broadcast_map])) begin
        $display("RENAME ERROR at %0t: broadcast of non-busy register", $time);
        $stop;
      end
      if ((int'(free_cnt_q) + $countones(~free_q)) != PHYS_REGS) begin
        $display("RENAME ERROR at %0t: free_count plus live mappings mismatch", $time);
        $stop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: a table-level rename model checked every
// cycle, plus hand-computed expectations from the rename scenarios.
module tb_rename_map;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   instr_ctr;

  rename_map_if rif ();

  rename_map dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (rif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  int m_rat  [32];
  int m_rrat [32];
  bit m_free [64];
  bit m_busy [64];
  bit m_on;
  bit e_valid;
  int e_num, e_a, e_b, e_wr;

  function automatic int m_free_cnt();
    int c = 0;
    for (int q = 0; q < 64; q++) c += int'(m_free[q]);
    return c;
  endfunction

  function automatic logic [63:0] m_busy_vec();
    logic [63:0] v;
    for (int q = 0; q < 64; q++) v[q] = m_busy[q];
    return v;
  endfunction

  function automatic bit m_ready();
    bit nd = rif.dec_wr && (rif.dec_dst != 0);
    return !rif.STALL && !rif.FLUSH && (!nd || (m_free_cnt() != 0));
  endfunction

  task automatic model_step();
    bit pre [64];
    bit nd, acc;
    int old, p;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_rat[i]  = i;
        m_rrat[i] = i;
      end
      for (int q = 0; q < 64; q++) begin
        m_free[q] = (q >= 32);
        m_busy[q] = 1'b0;
      end
      e_valid = 0; e_num = 0; e_a = 0; e_b = 0; e_wr = 0;
      m_on = 1'b1;
      return;
    end
    if (!m_on) return;
    nd  = rif.dec_wr && (rif.dec_dst != 0);
    acc = rif.dec_valid && m_ready();
    pre = m_free;
    e_valid = 0; e_num = 0; e_a = 0; e_b = 0; e_wr = 0;
    if (rif.commit_valid && (rif.commit_dst != 0)) begin
      old = m_rrat[rif.commit_dst];
      m_rrat[rif.commit_dst] = int'(rif.commit_map);
      if (old != 0) m_free[old] = 1'b1;
    end
    if (rif.FLUSH) begin
      for (int q = 0; q < 64; q++) begin
        m_free[q] = (q != 0);
        m_busy[q] = 1'b0;
      end
      for (int i = 0; i < 32; i++) m_free[m_rrat[i]] = 1'b0;
      m_rat = m_rrat;
    end else begin
      if (rif.exe_broadcast && (rif.exe_broadcast_map != 0)) m_busy[rif.exe_broadcast_map] = 1'b0;
      if (rif.mem_broadcast && (rif.mem_broadcast_map != 0)) m_busy[rif.mem_broadcast_map] = 1'b0;
      if (acc) begin
        e_valid = 1;
        e_num   = int'(rif.dec_instr_num);
        e_a     = m_rat[rif.dec_src_a];
        e_b     = m_rat[rif.dec_src_b];
        if (nd) begin
          p = -1;
          for (int q = 1; q < 64; q++) if (pre[q] && (p < 0)) p = q;
          e_wr = p;
          m_rat[rif.dec_dst] = p;
          m_free[p] = 1'b0;
          m_busy[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs are stable 2 time units after the falling edge.
  initial begin
    m_on = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (m_on && !rst) chk("dec_ready", 64'(rif.dec_ready), 64'(m_ready()));
      model_step();
      @(posedge clk);
      #1;
      if (m_on) begin
        chk("ren_valid",     64'(rif.ren_valid),     64'(e_valid));
        chk("ren_instr_num", 64'(rif.ren_instr_num), 64'(e_num));
        chk("ren_map_a",     64'(rif.ren_map_a),     64'(e_a));
        chk("ren_map_b",     64'(rif.ren_map_b),     64'(e_b));
        chk("ren_map_wr",    64'(rif.ren_map_wr),    64'(e_wr));
        chk("busy",          rif.busy,               m_busy_vec());
        chk("free_count",    64'(rif.free_count),    64'(m_free_cnt()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rif.STALL = 0; rif.FLUSH = 0;
    rif.dec_valid = 0; rif.dec_instr_num = '0; rif.dec_src_a = '0;
    rif.dec_src_b = '0; rif.dec_dst = '0; rif.dec_wr = 0;
    rif.exe_broadcast = 0; rif.exe_broadcast_map = '0;
    rif.mem_broadcast = 0; rif.mem_broadcast_map = '0;
    rif.commit_valid = 0; rif.commit_dst = '0; rif.commit_map = '0;
  endtask

  task automatic dec(input bit v, input int sa, input int sb, input int d, input bit w);
    rif.dec_valid     = v;
    rif.dec_src_a     = 5'(sa);
    rif.dec_src_b     = 5'(sb);
    rif.dec_dst       = 5'(d);
    rif.dec_wr        = w;
    rif.dec_instr_num = 32'(instr_ctr);
    instr_ctr++;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    go();
    rst = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; instr_ctr = 100;
    rst = 1;
    quiet();
    go(); go();
    rst = 0;
    chk("lit_reset_free", 64'(rif.free_count), 64'd32);
    chk("lit_reset_busy", rif.busy, 64'd0);
    chk("lit_reset_valid", 64'(rif.ren_valid), 64'd0);

    // r3 = r1 + r2, then r4 = r3 + r3 with a broadcast of 32
    dec(1, 1, 2, 3, 1); go();
    chk("lit_a_valid", 64'(rif.ren_valid), 64'd1);
    chk("lit_a_map_a", 64'(rif.ren_map_a), 64'd1);
    chk("lit_a_map_b", 64'(rif.ren_map_b), 64'd2);
    chk("lit_a_map_wr", 64'(rif.ren_map_wr), 64'd32);
    chk("lit_a_busy32", 64'(rif.busy[32]), 64'd1);
    chk("lit_a_free", 64'(rif.free_count), 64'd31);
    dec(1, 3, 3, 4, 1);
    rif.exe_broadcast = 1; rif.exe_broadcast_map = 6'd32;
    go();
    chk("lit_b_map_a", 64'(rif.ren_map_a), 64'd32);
    chk("lit_b_map_b", 64'(rif.ren_map_b), 64'd32);
    chk("lit_b_map_wr", 64'(rif.ren_map_wr), 64'd33);
    chk("lit_b_busy32", 64'(rif.busy[32]), 64'd0);
    chk("lit_b_busy33", 64'(rif.busy[33]), 64'd1);

    // exhaust the free list with writes to r5
    do_reset();
    for (int i = 0; i < 32; i++) begin
      dec(1, 5, 0, 5, 1); go();
      chk("lit_fill_map_wr", 64'(rif.ren_map_wr), 64'(32 + i));
    end
    chk("lit_empty_free", 64'(rif.free_count), 64'd0);
    dec(1, 1, 2, 6, 1); #1;
    chk("lit_empty_ready", 64'(rif.dec_ready), 64'd0);
    go();
    chk("lit_empty_valid", 64'(rif.ren_valid), 64'd0);
    dec(1, 5, 0, 7, 0); #1;
    chk("lit_nowr_ready", 64'(rif.dec_ready), 64'd1);
    go();
    chk("lit_nowr_valid", 64'(rif.ren_valid), 64'd1);
    chk("lit_nowr_map_a", 64'(rif.ren_map_a), 64'd63);
    chk("lit_nowr_map_wr", 64'(rif.ren_map_wr), 64'd0);
    quiet();
    rif.commit_valid = 1; rif.commit_dst = 5'd5; rif.commit_map = 6'd32;
    go();
    chk("lit_commit_free", 64'(rif.free_count), 64'd1);
    quiet();
    dec(1, 0, 0, 6, 1); go();
    chk("lit_reuse_map_wr", 64'(rif.ren_map_wr), 64'd5);
    chk("lit_reuse_free", 64'(rif.free_count), 64'd0);

    // stall and r0 destination
    do_reset();
    rif.STALL = 1;
    dec(1, 1, 2, 8, 1); #1;
    chk("lit_stall_ready", 64'(rif.dec_ready), 64'd0);
    go();
    chk("lit_stall_valid", 64'(rif.ren_valid), 64'd0);
    chk("lit_stall_free", 64'(rif.free_count), 64'd32);
    quiet();
    dec(1, 8, 0, 9, 1); go();
    chk("lit_stall_rat", 64'(rif.ren_map_a), 64'd8);
    chk("lit_post_stall_wr", 64'(rif.ren_map_wr), 64'd32);
    dec(1, 9, 0, 0, 1); go();
    chk("lit_r0_map_wr", 64'(rif.ren_map_wr), 64'd0);
    chk("lit_r0_free", 64'(rif.free_count), 64'd31);

    // commit plus flush recovery
    do_reset();
    dec(1, 0, 0, 3, 1); go();
    dec(1, 0, 0, 4, 1); go();
    quiet();
    rif.commit_valid = 1; rif.commit_dst = 5'd3; rif.commit_map = 6'd32;
    rif.FLUSH = 1;
    dec(1, 0, 0, 12, 1); #1;
    chk("lit_flush_ready", 64'(rif.dec_ready), 64'd0);
    go();
    chk("lit_flush_busy", rif.busy, 64'd0);
    chk("lit_flush_free", 64'(rif.free_count), 64'd32);
    chk("lit_flush_valid", 64'(rif.ren_valid), 64'd0);
    quiet();
    dec(1, 3, 4, 0, 0); go();
    chk("lit_flush_rat3", 64'(rif.ren_map_a), 64'd32);
    chk("lit_flush_rat4", 64'(rif.ren_map_b), 64'd4);
    dec(1, 0, 0, 10, 1);
    rif.exe_broadcast = 1; rif.exe_broadcast_map = 6'd3;
    go();
    chk("lit_reclaim_wr", 64'(rif.ren_map_wr), 64'd3);
    chk("lit_set_wins", 64'(rif.busy[3]), 64'd1);
    quiet();
    rif.commit_valid = 1; rif.commit_dst = 5'd10; rif.commit_map = 6'd3;
    dec(1, 10, 0, 11, 1); go();
    chk("lit_precommit_wr", 64'(rif.ren_map_wr), 64'd33);
    chk("lit_precommit_a", 64'(rif.ren_map_a), 64'd3);
    quiet();
    dec(1, 0, 0, 12, 1); go();
    chk("lit_freed_wr", 64'(rif.ren_map_wr), 64'd10);
    quiet();
    rif.exe_broadcast = 1; rif.exe_broadcast_map = 6'd3;
    rif.mem_broadcast = 1; rif.mem_broadcast_map = 6'd33;
    go();
    chk("lit_dual_bc3", 64'(rif.busy[3]), 64'd0);
    chk("lit_dual_bc33", 64'(rif.busy[33]), 64'd0);
    chk("lit_dual_bc10", 64'(rif.busy[10]), 64'd1);

    // reset wins over flush
    quiet();
    rif.FLUSH = 1; rst = 1;
    dec(1, 0, 0, 13, 1); go();
    rst = 0;
    quiet();
    chk("lit_rstflush_free", 64'(rif.free_count), 64'd32);
    chk("lit_rstflush_busy", rif.busy, 64'd0);
    chk("lit_rstflush_valid", 64'(rif.ren_valid), 64'd0);
    dec(1, 3, 10, 0, 0); go();
    chk("lit_rstflush_rat3", 64'(rif.ren_map_a), 64'd3);
    chk("lit_rstflush_rat10", 64'(rif.ren_map_b), 64'd10);

    quiet();
    go(); go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
